divider_64bit_seq: RTL

- Multi-cycle radix-2 restoring divider for the execute stage; the inverse of the combinational 64x64 multiplier datapath.
- Implements RV64M DIV, DIVU, REM and REMU.
- Pipeline holds the instruction while o_busy is high and captures the result on the o_valid pulse.
- One operation in flight; fixed, deterministic latency.

---
 rtl/div_pkg.sv | 26 ++
 rtl/div_step.sv | 34 +++
 rtl/divider_64bit_seq.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential RV64M divider.
//   div_op_e     : operation encoding as presented on i_op
//   div_state_e  : divider FSM states
//   DIV_XLEN     : default operand/result width
//   DIV_LATENCY  : clock edges from the accept edge to the edge that samples o_valid
package div_pkg;

    localparam int DIV_XLEN    = 64;
    localparam int DIV_CNT_W   = 7;
    localparam int DIV_LATENCY = DIV_XLEN + 2;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration (purely combinational).
//   rem, quo  : current partial remainder and quotient/dividend shift register
//   divisor   : divisor magnitude
//   rem_next, quo_next : values after shifting in one dividend bit and the
//                        trial subtraction
module div_step #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quo_next
);

    // The shifted remainder needs one extra bit: rem < divisor, so 2*rem+1
    // can exceed XLEN bits. The difference always lies in [-divisor, divisor),
    // so its top bit is a reliable sign.
    logic [XLEN:0] rem_sh;
    logic [XLEN:0] diff;

    assign rem_sh = {rem, quo[XLEN-1]};
    assign diff   = rem_sh - {1'b0, divisor};

    always_comb begin
        rem_next = rem_sh[XLEN-1:0];
        quo_next = {quo[XLEN-2:0], 1'b0};
        if (!diff[XLEN]) begin
            rem_next = diff[XLEN-1:0];
            quo_next = {quo[XLEN-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/divider_64bit_seq.sv
// Multi-cycle radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU.
// Ports:
//   i_clk, i_reset        : clock, asynchronous active-high reset
//   i_start, i_kill       : request and pipeline flush
//   i_op                  : 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   i_dividend, i_divisor : rs1, rs2
//   o_busy, o_valid       : operation in flight, one-cycle result strobe
//   o_result              : quotient or remainder, held until the next accept
//   o_dbg_state           : current FSM state (div_state_e encoding)
// Optional build macro DIVIDER_FAST_PATH_EN: divide-by-zero, signed overflow
// and |dividend| < |divisor| skip the iteration loop and finish in two cycles.
//
// Handshake: i_start is a request accepted on a rising edge only when the FSM
// is IDLE and i_kill is low; there is no ready output, the issuer sees the
// accept as o_busy rising the cycle after. o_valid pulses for exactly one
// cycle (DONE) and o_result is valid from that cycle until the next accept.
module divider_64bit_seq
    import div_pkg::*;
#(
    parameter int XLEN  = DIV_XLEN,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_start,
    input  logic            i_kill,
    input  logic [1:0]      i_op,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    output logic            o_busy,
    output logic            o_valid,
    output logic [XLEN-1:0] o_result,
    output logic [1:0]      o_dbg_state
);

    localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e      state, state_d;
    logic [CNT_W-1:0] cnt;
    div_op_e         op_q;
    logic            sign_q, sign_r, dvz_q;
    logic [XLEN-1:0] rem_q, quo_q, dvs_q, result_q;

    logic            accept, is_signed, dvd_neg, dvs_neg, fast_hit;
    logic [XLEN-1:0] dvd_abs, dvs_abs, start_rem, start_quo;
    logic [XLEN-1:0] rem_n, quo_n, quo_fix, rem_fix, result_d;

    assign accept    = (state == S_IDLE) && i_start && !i_kill;
    assign is_signed = ~i_op[0];
    assign dvd_neg   = is_signed & i_dividend[XLEN-1];
    assign dvs_neg   = is_signed & i_divisor[XLEN-1];
    assign dvd_abs   = dvd_neg ? -i_dividend : i_dividend;
    assign dvs_abs   = dvs_neg ? -i_divisor  : i_divisor;

`ifdef DIVIDER_FAST_PATH_EN
    logic fast_dvz, fast_ovf;
    assign fast_dvz = (i_divisor == '0);
    assign fast_ovf = is_signed && (i_dividend == XMIN) && (&i_divisor);
    assign fast_hit = fast_dvz || fast_ovf || (dvd_abs < dvs_abs);

    // Preload the registers with the final magnitudes so FIX sees the same
    // values the iteration loop would have produced.
    always_comb begin
        start_rem = '0;
        start_quo = dvd_abs;
        if (fast_dvz) begin
            start_rem = dvd_abs;
            start_quo = '1;
        end else if (fast_ovf) begin
            start_rem = '0;
            start_quo = XMIN;
        end else if (fast_hit) begin
            start_rem = dvd_abs;
            start_quo = '0;
        end
    end
`else
    assign fast_hit  = 1'b0;
    assign start_rem = '0;
    assign start_quo = dvd_abs;
`endif

    div_step #(.XLEN(XLEN)) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (dvs_q),
        .rem_next (rem_n),
        .quo_next (quo_n)
    );

    // Signed divide-by-zero: sign_q would flip the all-ones quotient, so it
    // is forced. The remainder needs no special case: negating |dividend|
    // under sign_r restores the original dividend.
    assign quo_fix = dvz_q ? '1 : (sign_q ? -quo_q : quo_q);
    assign rem_fix = sign_r ? -rem_q : rem_q;

    always_comb begin
        case (op_q)
            OP_DIV, OP_DIVU: result_d = quo_fix;
            default:         result_d = rem_fix;
        endcase
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: if (accept) state_d = fast_hit ? S_FIX : S_CALC;
            S_CALC: if (cnt == CNT_W'(XLEN-1)) state_d = S_FIX;
            S_FIX:  state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (i_kill && state != S_IDLE) state_d = S_IDLE;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state <= S_IDLE;
        else         state <= state_d;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt      <= '0;
            op_q     <= OP_DIV;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            dvz_q    <= 1'b0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            result_q <= '0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    op_q   <= div_op_e'(i_op);
                    sign_q <= dvd_neg ^ dvs_neg;
                    sign_r <= dvd_neg;
                    dvz_q  <= (i_divisor == '0);
                    dvs_q  <= dvs_abs;
                    rem_q  <= start_rem;
                    quo_q  <= start_quo;
                    cnt    <= '0;
                end
                S_CALC: begin
                    rem_q <= rem_n;
                    quo_q <= quo_n;
                    cnt   <= cnt + CNT_W'(1);
                end
                S_FIX: if (!i_kill) result_q <= result_d;
                default: ;
            endcase
        end
    end

    assign o_busy      = (state == S_CALC) || (state == S_FIX);
    assign o_valid     = (state == S_DONE);
    assign o_result    = result_q;
    assign o_dbg_state = state;

endmodule
